// File: rtl/core_pkg.sv
// Shared constants and types for the E0C6S46 core's program-memory path.
package core_pkg;

   localparam int unsigned OP_W = 12;
   localparam int unsigned PC_W = 13;

   localparam logic [OP_W-1:0] NOP5 = 12'hFFB;

   typedef enum logic [1:0] {
      EMPTY,
      LOAD_HI,
      LOAD_LO,
      LOADED
   } load_state_e;

endpackage

// File: rtl/rom_bram.sv
// Simple dual-port program memory: one write port, one registered read port.
module rom_bram
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 6144,
   parameter int unsigned DW    = OP_W,
   parameter int unsigned AW    = PC_W
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Contents survive reset; the loader always rewrites the full image.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rom_fetch_server.sv
// Program-memory responder: byte-stream image loader plus a 2-cycle fetch pipe
// that keeps the core halted until the whole image is present.
module rom_fetch_server
   import core_pkg::*;
#(
   parameter int unsigned     ROM_WORDS = 6144,
   parameter logic [OP_W-1:0] FILL_WORD = NOP5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cpu_fetch,
   input  logic [PC_W-1:0] cpu_addr,
   output logic [OP_W-1:0] cpu_data,
   output logic            cpu_data_valid,
   output logic            cpu_halt,
   input  logic            load_valid,
   input  logic [7:0]      load_data,
   output logic            load_ready,
   input  logic            load_restart,
   output logic            load_done
);

   localparam logic [PC_W-1:0] ROM_LIMIT = PC_W'(ROM_WORDS);
   localparam logic [PC_W-1:0] LAST_WORD = PC_W'(ROM_WORDS - 1);

   load_state_e     state_q;
   logic [PC_W-1:0] word_ptr_q;
   logic [3:0]      hi_q;
   logic            load_ready_q;
   logic            load_done_q;
   logic            cpu_halt_q;

   logic            fetch_v1_q;
   logic            fetch_oor1_q;
   logic            cpu_data_valid_q;
   logic [OP_W-1:0] cpu_data_q;
   logic [OP_W-1:0] cpu_data_d;
   logic [OP_W-1:0] rd_data;

   logic            load_accept_c;
   logic            rom_we_c;
   logic            fetch_accept_c;
   logic            in_range_c;
   logic            deliver_c;

   // A byte offered in the restart cycle is never taken.
   assign load_accept_c  = load_valid & load_ready_q & ~load_restart;
   assign rom_we_c       = load_accept_c & (state_q == LOAD_LO);
   assign fetch_accept_c = cpu_fetch & ~cpu_halt_q & ~load_restart;
   assign in_range_c     = cpu_addr < ROM_LIMIT;
   assign deliver_c      = fetch_v1_q & ~load_restart;
   assign cpu_data_d     = deliver_c ? (fetch_oor1_q ? FILL_WORD : rd_data) : cpu_data_q;

   rom_bram #(
      .DEPTH (ROM_WORDS),
      .DW    (OP_W),
      .AW    (PC_W)
   ) u_rom (
      .clk_i   (clk),
      .we_i    (rom_we_c),
      .waddr_i (word_ptr_q),
      .wdata_i ({hi_q, load_data}),
      .re_i    (fetch_accept_c & in_range_c),
      .raddr_i (cpu_addr),
      .rdata_o (rd_data)
   );

   // Loader FSM: two big-endian bytes per word, high byte carries opcode[11:8].
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= EMPTY;
         word_ptr_q   <= '0;
         hi_q         <= '0;
         load_ready_q <= 1'b0;
         load_done_q  <= 1'b0;
         cpu_halt_q   <= 1'b1;
      end else if (load_restart) begin
         state_q      <= LOAD_HI;
         word_ptr_q   <= '0;
         load_ready_q <= 1'b1;
         load_done_q  <= 1'b0;
         cpu_halt_q   <= 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               state_q      <= LOAD_HI;
               load_ready_q <= 1'b1;
            end
            LOAD_HI: begin
               if (load_accept_c) begin
                  hi_q    <= load_data[3:0];
                  state_q <= LOAD_LO;
               end
            end
            LOAD_LO: begin
               if (load_accept_c) begin
                  if (word_ptr_q == LAST_WORD) begin
                     state_q      <= LOADED;
                     load_ready_q <= 1'b0;
                     load_done_q  <= 1'b1;
                     cpu_halt_q   <= 1'b0;
                  end else begin
                     word_ptr_q <= word_ptr_q + PC_W'(1);
                     state_q    <= LOAD_HI;
                  end
               end
            end
            LOADED: begin
               load_ready_q <= 1'b0;
            end
            default: begin
               state_q <= EMPTY;
            end
         endcase
      end
   end

   // Fetch pipe: stage 1 is the BRAM read, stage 2 the range mux and output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_v1_q       <= 1'b0;
         fetch_oor1_q     <= 1'b0;
         cpu_data_valid_q <= 1'b0;
         cpu_data_q       <= '0;
      end else begin
         fetch_v1_q       <= fetch_accept_c;
         fetch_oor1_q     <= ~in_range_c;
         cpu_data_valid_q <= deliver_c;
         cpu_data_q       <= cpu_data_d;
      end
   end

   assign cpu_data       = cpu_data_q;
   assign cpu_data_valid = cpu_data_valid_q;
   assign cpu_halt       = cpu_halt_q;
   assign load_ready     = load_ready_q;
   assign load_done      = load_done_q;

endmodule

// File: tb/tb_rom_fetch_server.sv
// Bench for rom_fetch_server: image loads, fetch table, random fetches vs a
// queue-based response model, restart squash and async reset mid-load.
module tb_rom_fetch_server;

   localparam int WORDS = 6144;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_fetch;
   logic [12:0] cpu_addr;
   logic [11:0] cpu_data;
   logic        cpu_data_valid;
   logic        cpu_halt;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_ready;
   logic        load_restart;
   logic        load_done;

   rom_fetch_server dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_fetch      (cpu_fetch),
      .cpu_addr       (cpu_addr),
      .cpu_data       (cpu_data),
      .cpu_data_valid (cpu_data_valid),
      .cpu_halt       (cpu_halt),
      .load_valid     (load_valid),
      .load_data      (load_data),
      .load_ready     (load_ready),
      .load_restart   (load_restart),
      .load_done      (load_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [11:0] data;
   } resp_t;

   typedef struct {
      logic        f;
      logic [12:0] a;
      logic        v;
      logic [11:0] d;
   } vec_t;

   resp_t       q[$];
   logic [11:0] img  [WORDS];
   logic [3:0]  junk [WORDS];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   bit          mon_en   = 1'b0;
   bit          model_run = 1'b0;
   logic [11:0] mon_last = 12'h000;
   logic        mon_exp_v;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [11:0] ref_fetch(input logic [12:0] a);
      return (int'(a) < WORDS) ? img[a] : 12'hFFB;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drive a fetch for the current cycle; the model expects a reply 2 cycles on if serviced.
   task automatic set_fetch(input logic f, input logic [12:0] a);
      cpu_fetch = f;
      cpu_addr  = a;
      if (f && model_run && !load_restart) q.push_back('{due: cyc + 2, data: ref_fetch(a)});
   endtask

   task automatic rand_fetch();
      logic [12:0] a;
      if ($urandom_range(3) == 0) a = 13'($urandom_range(8191, 6144));
      else a = 13'($urandom_range(6143));
      set_fetch($urandom_range(99) < 60, a);
   endtask

   task automatic push_byte(input logic [7:0] b, input int gap);
      logic rdy;
      bit   acc;
      while (int'($urandom_range(99)) < gap) begin
         load_valid = 1'b0;
         rand_fetch();
         next_cycle();
      end
      load_valid = 1'b1;
      load_data  = b;
      acc = 1'b0;
      for (int t = 0; t < 16 && !acc; t++) begin
         rand_fetch();
         @(negedge clk);
         rdy = load_ready;
         next_cycle();
         acc = rdy;
      end
      load_valid = 1'b0;
      if (!acc) chk("load_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic load_image(input int gap);
      for (int w = 0; w < WORDS; w++) begin
         push_byte({junk[w], img[w][11:8]}, gap);
         push_byte(img[w][7:0], gap);
         if (w == 1) begin
            chk("ready_mid_load", 32'(load_ready), 32'd1);
            chk("done_mid_load", 32'(load_done), 32'd0);
            chk("halt_mid_load", 32'(cpu_halt), 32'd1);
         end
      end
      chk("done_after_last", 32'(load_done), 32'd1);
      chk("halt_after_last", 32'(cpu_halt), 32'd0);
      chk("ready_after_last", 32'(load_ready), 32'd0);
      set_fetch(1'b0, 13'h0);
      model_run = 1'b1;
   endtask

   task automatic new_image(input logic [11:0] w0, input logic [3:0] j0);
      for (int w = 0; w < WORDS; w++) begin
         img[w]  = 12'($urandom);
         junk[w] = 4'($urandom);
      end
      img[0]  = w0;
      junk[0] = j0;
   endtask

   // Response monitor: every serviced fetch appears exactly at its due cycle; data holds otherwise.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_exp_v = (q.size() != 0) && (q[0].due == cyc);
         chk("mon_valid", 32'(cpu_data_valid), 32'(mon_exp_v));
         if (mon_exp_v) begin
            mon_last = q[0].data;
            q.delete(0);
         end
         chk("mon_data", 32'(cpu_data), 32'(mon_last));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl [9];
      tbl[0] = '{1'b1, 13'h0000, 1'b0, 12'h000};
      tbl[1] = '{1'b1, 13'h0001, 1'b0, 12'h000};
      tbl[2] = '{1'b1, 13'h0000, 1'b1, 12'h2CD};
      tbl[3] = '{1'b1, 13'h1800, 1'b1, 12'h3F1};
      tbl[4] = '{1'b1, 13'h1FFF, 1'b1, 12'h2CD};
      tbl[5] = '{1'b0, 13'h0000, 1'b1, 12'hFFB};
      tbl[6] = '{1'b0, 13'h0000, 1'b1, 12'hFFB};
      tbl[7] = '{1'b0, 13'h0000, 1'b0, 12'hFFB};
      tbl[8] = '{1'b0, 13'h0000, 1'b0, 12'hFFB};

      reset        = 1'b1;
      cpu_fetch    = 1'b0;
      cpu_addr     = 13'h0;
      load_valid   = 1'b0;
      load_data    = 8'h00;
      load_restart = 1'b0;

      @(negedge clk);
      chk("rst_data", 32'(cpu_data), 32'd0);
      chk("rst_valid", 32'(cpu_data_valid), 32'd0);
      chk("rst_halt", 32'(cpu_halt), 32'd1);
      chk("rst_ready", 32'(load_ready), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      next_cycle();
      reset  = 1'b0;
      mon_en = 1'b1;
      chk("empty_ready", 32'(load_ready), 32'd0);
      next_cycle();
      chk("load_hi_ready", 32'(load_ready), 32'd1);

      // Async reset in the middle of a load.
      push_byte(8'h5A, 0);
      push_byte(8'hA5, 0);
      load_valid = 1'b1;
      load_data  = 8'h11;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_ready", 32'(load_ready), 32'd0);
      chk("async_rst_halt", 32'(cpu_halt), 32'd1);
      load_valid = 1'b0;
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // Full image with gaps; fetches during load must be ignored.
      new_image(12'h2CD, 4'h0);
      img[1]  = 12'h3F1;
      junk[1] = 4'hF;
      load_image(25);

      load_valid = 1'b1;
      load_data  = 8'h77;
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         chk("loaded_ready", 32'(load_ready), 32'd0);
         chk("loaded_done", 32'(load_done), 32'd1);
      end
      load_valid = 1'b0;

      mon_en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cpu_fetch = tbl[i].f;
         cpu_addr  = tbl[i].a;
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i), 32'(cpu_data_valid), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_data", i), 32'(cpu_data), 32'(tbl[i].d));
         next_cycle();
      end
      cpu_fetch = 1'b0;
      mon_last  = 12'hFFB;
      mon_en    = 1'b1;

      for (int i = 0; i < 400; i++) begin
         rand_fetch();
         next_cycle();
      end
      set_fetch(1'b0, 13'h0);
      repeat (3) next_cycle();

      // Restart one cycle after a fetch squashes its reply.
      set_fetch(1'b1, 13'd1);
      next_cycle();
      load_restart = 1'b1;
      model_run    = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].due > cyc) q.delete(i);
      set_fetch(1'b1, 13'd0);
      next_cycle();
      load_restart = 1'b0;
      set_fetch(1'b0, 13'h0);
      chk("squash_valid", 32'(cpu_data_valid), 32'd0);
      chk("restart_halt", 32'(cpu_halt), 32'd1);
      chk("restart_done", 32'(load_done), 32'd0);
      chk("restart_ready", 32'(load_ready), 32'd1);

      new_image(12'hABC, 4'h0);
      load_image(0);
      set_fetch(1'b1, 13'h0);
      next_cycle();
      set_fetch(1'b0, 13'h0);
      next_cycle();
      chk("reload_valid", 32'(cpu_data_valid), 32'd1);
      chk("reload_data", 32'(cpu_data), 32'h0ABC);

      for (int i = 0; i < 150; i++) begin
         rand_fetch();
         next_cycle();
      end
      set_fetch(1'b0, 13'h0);
      repeat (3) next_cycle();
      chk("queue_drained", 32'(q.size()), 32'd0);
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rom_fetch_server.md
Name: rom_fetch_server

Overview:
- Program-memory responder for the E0C6S46 CPU core.
- Answers the core's instruction-fetch requests (13-bit PC in, 12-bit opcode out) with fixed latency.
- Owns the ROM image, which a byte-wide loader stream writes at boot.
- Sits between the core's fetch port and the host bridge download path.
- Holds the core halted until a complete image has been written.

Parameters:
- ROM_WORDS, 6144: number of 12-bit program words; valid addresses are 0 to ROM_WORDS-1.
- FILL_WORD, 12'hFFB: opcode returned for out-of-range fetches (NOP5).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- cpu_fetch  in  1  single-cycle fetch request strobe
- cpu_addr  in  13  PC to fetch, sampled with cpu_fetch
- cpu_data  out  12  opcode
- cpu_data_valid  out  1  single-cycle pulse; cpu_data is valid in this cycle
- cpu_halt  out  1  high until the image is fully loaded
- load_valid  in  1  loader byte valid
- load_data  in  8  loader byte
- load_ready  out  1  loader byte accepted when load_valid & load_ready
- load_restart  in  1  single-cycle pulse; discard the image and reload from word 0
- load_done  out  1  level; image complete

Behaviour:
- Reset values: cpu_data=0, cpu_data_valid=0, cpu_halt=1, load_ready=0, load_done=0. Reset also clears the load FSM and the fetch pipe. ROM contents are not cleared.
- Load FSM states: EMPTY, LOAD_HI, LOAD_LO, LOADED.
- EMPTY -> LOAD_HI on the first clock after reset deasserts. load_ready=1 in LOAD_HI and LOAD_LO.
- LOAD_HI, on accept: latch byte[3:0] as opcode[11:8]; byte[7:4] is ignored. -> LOAD_LO.
- LOAD_LO, on accept: write {hi_nibble, byte} to ROM[word_ptr], then word_ptr+1.
  - If word_ptr was ROM_WORDS-1: -> LOADED.
  - Otherwise: -> LOAD_HI.
- LOADED: load_ready=0, load_done=1. cpu_halt falls in the same cycle load_done rises.
- load_restart in any state: -> LOAD_HI next cycle, with word_ptr=0, load_done=0, cpu_halt=1. A byte presented in the restart cycle is not accepted.
- Byte order is big-endian 16 bits per word (file format of the ROM dump). word_ptr is 13 bits and never wraps past ROM_WORDS-1.
- Fetch pipe is fully pipelined: one request per cycle accepted, latency 2.
  - Cycle N: cpu_fetch=1 with cpu_addr.
  - Cycle N+2: cpu_data_valid=1 with cpu_data.
- Stage 1 is the registered BRAM read. Stage 2 is the output register and the range mux.
- cpu_addr >= ROM_WORDS returns FILL_WORD (e.g. 13'h1800 and 13'h1FFF).
- Fetches are serviced only while cpu_halt=0.
  - A cpu_fetch while cpu_halt=1 is dropped: no valid pulse, cpu_data holds its last value.
- cpu_data holds its value between valid pulses.
- If load_restart occurs with fetches in flight, the in-flight valid pulses are squashed.
- A simultaneous ROM write and fetch is impossible, because fetches are gated by cpu_halt.
- Asynchronous reset mid-load or mid-fetch: all state returns to reset values immediately. The loader must restart from byte 0.

Decomposition:
- Shared package core_pkg holds:
  - the opcode width (12) and PC width (13) constants;
  - NOP5 = 12'hFFB;
  - the load FSM state enum typedef.
- One sub-module: rom_bram, a simple dual-port 12-bit memory (one write port, one registered read port).
- Everything else lives in rom_fetch_server.

Test Plan:
1. After reset, stream bytes 8'h02, 8'hCD, then 8'hF3, 8'hF1 -> ROM[0]=12'h2CD, ROM[1]=12'h3F1. The upper nibbles of 8'hF3 are ignored.
2. Load the full image (12288 bytes) -> load_done=1 and cpu_halt=0 in the cycle after the final byte is accepted; load_ready=0 afterwards.
3. cpu_fetch on back-to-back cycles with addresses 0, 1, 0 -> valid pulses 2 cycles later on three consecutive cycles, with data 12'h2CD, 12'h3F1, 12'h2CD.
4. Fetch address 13'h1800, then 13'h1FFF -> cpu_data=12'hFFB both times, latency 2.
5. Fetch during loading (cpu_halt=1) -> no cpu_data_valid pulse and cpu_data unchanged.
6. load_restart one cycle after a fetch to address 1 -> that valid pulse is squashed, cpu_halt=1, load_done=0. Reloading bytes 8'h0A, 8'hBC gives a fetch of address 0 returning 12'hABC.
